// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock sequencer that holds the core in reset until lock is stable
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_ATTEMPTS        = 4
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] attempt_cnt,
  output logic [7:0] loss_cnt
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  // The locked cycle that moves WAIT_LOCK into STABLE is the first stable cycle.
  localparam logic [CW-1:0] STABLE_LAST  = CW'((LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam logic [3:0]    ATT_MAX      = 4'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    attempt_nxt;
  logic [7:0]    loss_nxt;
  logic          sync1, locked_s;
  logic          clear;

  always_comb begin
    state_nxt   = state;
    attempt_nxt = attempt_cnt;
    loss_nxt    = loss_cnt;
    clear       = 1'b0;
    cnt_nxt     = cnt + CW'(1);

    // Lock loss in RUN always leaves RUN, whether or not a request coincides.
    if (state == S_RUN && !locked_s && loss_cnt != 8'hFF)
      loss_nxt = loss_cnt + 8'd1;

    if (relock_req) begin
      state_nxt   = S_RESET_PLL;
      attempt_nxt = 4'd0;
      clear       = 1'b1;
    end else begin
      case (state)
        S_RESET_PLL: if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (locked_s) begin
            if (LOCK_STABLE_CYCLES == 1) begin
              state_nxt   = S_RUN;
              attempt_nxt = 4'd0;
            end else begin
              state_nxt = S_STABLE;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            attempt_nxt = attempt_cnt + 4'd1;
            state_nxt   = (attempt_cnt + 4'd1 == ATT_MAX) ? S_FAIL : S_RESET_PLL;
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state_nxt = S_WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_nxt   = S_RUN;
            attempt_nxt = 4'd0;
          end
        end
        S_RUN:   if (!locked_s) state_nxt = S_RESET_PLL;
        S_FAIL:  state_nxt = S_FAIL;
        default: state_nxt = S_RESET_PLL;
      endcase
    end

    if (clear || state_nxt != state)
      cnt_nxt = '0;
    else if (state == S_RUN || state == S_FAIL)
      cnt_nxt = cnt;
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= 1'b0;
      locked_s     <= 1'b0;
      state        <= S_RESET_PLL;
      cnt          <= '0;
      attempt_cnt  <= 4'd0;
      loss_cnt     <= 8'd0;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      ready        <= 1'b0;
      fail         <= 1'b0;
    end else begin
      sync1        <= pll_locked;
      locked_s     <= sync1;
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      attempt_cnt  <= attempt_nxt;
      loss_cnt     <= loss_nxt;
      pll_rst      <= (state_nxt == S_RESET_PLL);
      core_reset_n <= (state_nxt == S_RUN);
      ready        <= (state_nxt == S_RUN);
      fail         <= (state_nxt == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - table-driven bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

  logic       clk_74a = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       core_reset_n;
  logic       ready;
  logic       fail;
  logic [3:0] attempt_cnt;
  logic [7:0] loss_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cycles;
    logic       locked;
    logic       relock;
    logic       pll_rst;
    logic       ready;
    logic       fail;
    logic [3:0] att;
    logic [7:0] loss;
  } vec_t;

  vec_t vecs[$];

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES(8),
    .MAX_ATTEMPTS(2)
  ) dut (
    .clk_74a(clk_74a),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst(pll_rst),
    .core_reset_n(core_reset_n),
    .ready(ready),
    .fail(fail),
    .attempt_cnt(attempt_cnt),
    .loss_cnt(loss_cnt)
  );

  always #5 clk_74a = ~clk_74a;

  // Packed view: {pll_rst, core_reset_n, ready, fail, attempt_cnt, loss_cnt}
  function automatic logic [15:0] expv(input logic pr, input logic rdy, input logic fl,
                                       input int att, input int loss);
    return {pr, rdy, rdy, fl, 4'(att), 8'(loss)};
  endfunction

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {pll_rst, core_reset_n, ready, fail, attempt_cnt, loss_cnt};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rst/crn/rdy/fail=%b attempt=%0d loss=%0d, expected rst/crn/rdy/fail=%b attempt=%0d loss=%0d",
               name, act[15:12], act[11:8], act[7:0], exp[15:12], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk_74a);
    #1;
  endtask

  task automatic add(input int n, input logic lk, input logic rq, input logic pr,
                     input logic rdy, input logic fl, input int att, input int loss);
    vec_t v;
    v.cycles = n;  v.locked = lk; v.relock = rq;
    v.pll_rst = pr; v.ready = rdy; v.fail = fl;
    v.att = 4'(att); v.loss = 8'(loss);
    vecs.push_back(v);
  endtask

  initial begin
    int  exp_loss;
    bit  seen;

    // cycles, locked, relock | pll_rst, ready, fail, attempt, loss (held after every edge of the row)
    // Bring-up: lock raised 10 edges after pll_rst falls, ready on the 10th edge after that.
    add(3,  0, 0, 1, 0, 0, 0, 0);
    add(11, 0, 0, 0, 0, 0, 0, 0);
    add(9,  1, 0, 0, 0, 0, 0, 0);
    add(6,  1, 0, 0, 1, 0, 0, 0);
    // Lock loss in RUN, then recovery.
    add(2,  0, 0, 0, 1, 0, 0, 0);
    add(4,  0, 0, 1, 0, 0, 0, 1);
    add(9,  1, 0, 0, 0, 0, 0, 1);
    add(4,  1, 0, 0, 1, 0, 0, 1);
    // Relock with lock held, then a one-cycle glitch after 5 stable cycles.
    add(1,  1, 1, 1, 0, 0, 0, 1);
    add(3,  1, 0, 1, 0, 0, 0, 1);
    add(6,  1, 0, 0, 0, 0, 0, 1);
    add(1,  0, 0, 0, 0, 0, 0, 1);
    add(9,  1, 0, 0, 0, 0, 0, 1);
    add(3,  1, 0, 0, 1, 0, 0, 1);
    // Request on the same edge the synchronized lock falls in RUN.
    add(2,  0, 0, 0, 1, 0, 0, 1);
    add(1,  0, 1, 1, 0, 0, 0, 2);
    add(3,  0, 0, 1, 0, 0, 0, 2);
    add(9,  1, 0, 0, 0, 0, 0, 2);
    add(3,  1, 0, 0, 1, 0, 0, 2);
    // Timeouts: two pulses 36 edges apart, FAIL, then relock.
    add(1,  0, 1, 1, 0, 0, 0, 2);
    add(3,  0, 0, 1, 0, 0, 0, 2);
    add(32, 0, 0, 0, 0, 0, 0, 2);
    add(4,  0, 0, 1, 0, 0, 1, 2);
    add(32, 0, 0, 0, 0, 0, 1, 2);
    add(100,0, 0, 0, 0, 1, 2, 2);
    add(1,  0, 1, 1, 0, 0, 0, 2);
    add(3,  0, 0, 1, 0, 0, 0, 2);
    add(2,  0, 0, 0, 0, 0, 0, 2);

    reset_n    = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    repeat (2) begin
      tick();
      check("reset_state", expv(1, 0, 0, 0, 0));
    end
    reset_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      pll_locked = vecs[r].locked;
      relock_req = vecs[r].relock;
      for (int k = 0; k < vecs[r].cycles; k++) begin
        tick();
        check($sformatf("row%0d_edge%0d", r, k),
              expv(vecs[r].pll_rst, vecs[r].ready, vecs[r].fail, vecs[r].att, vecs[r].loss));
      end
    end
    relock_req = 1'b0;

    // Repeated losses until loss_cnt saturates.
    exp_loss = 2;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
        tick();
        if (ready) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL loss_loop_ready iter %0d: ready stayed 0 for 30 edges, expected 1", i);
      end
      pll_locked = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        tick();
        if (!core_reset_n) seen = 1'b1;
      end
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      check($sformatf("loss_sat_iter%0d", i), expv(1, 0, 0, 0, exp_loss));
    end

    // Build a nonzero attempt count, then reset asynchronously mid-WAIT_LOCK.
    repeat (36) tick();
    check("timeout_after_losses", expv(1, 0, 0, 1, 255));
    repeat (6) tick();
    check("wait_before_async_reset", expv(0, 0, 0, 1, 255));
    #3 reset_n = 1'b0;
    #1 check("async_reset_between_edges", expv(1, 0, 0, 0, 0));
    tick();
    check("reset_held", expv(1, 0, 0, 0, 0));
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("post_reset_pulse_edge%0d", k), expv((k < 4) ? 1'b1 : 1'b0, 0, 0, 0, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
